// File: rtl/alu_sequencer_if.sv
// Command, ALU-side, status and debug signals of the ALU operand/writeback sequencer.
// The slave modport is the sequencer; the master modport is the command source / ALU / debug side.
interface alu_sequencer_if #(
    parameter int BUS_SIZE  = 32,
    parameter int OP_W      = 8,
    parameter int FLAG_W    = 4,
    parameter int REG_COUNT = 8,
    parameter int RA_W      = $clog2(REG_COUNT)
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [OP_W-1:0]     cmd_op;
    logic [RA_W-1:0]     cmd_rd;
    logic [RA_W-1:0]     cmd_rs1;
    logic [RA_W-1:0]     cmd_rs2;
    logic                cmd_imm_en;
    logic [BUS_SIZE-1:0] cmd_imm;
    logic                cmd_use_carry;

    logic [OP_W-1:0]     alu_op;
    logic [BUS_SIZE-1:0] alu_a;
    logic [BUS_SIZE-1:0] alu_b;
    logic                alu_cin;
    logic [BUS_SIZE-1:0] alu_result;
    logic [FLAG_W-1:0]   alu_flags;

    logic [FLAG_W-1:0]   flags;
    logic                done;
    logic [RA_W-1:0]     done_rd;
    logic [RA_W-1:0]     dbg_addr;
    logic [BUS_SIZE-1:0] dbg_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_use_carry,
        output cmd_ready,
        output alu_op, alu_a, alu_b, alu_cin,
        input  alu_result, alu_flags,
        output flags, done, done_rd,
        input  dbg_addr,
        output dbg_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_use_carry,
        input  cmd_ready,
        input  alu_op, alu_a, alu_b, alu_cin,
        output alu_result, alu_flags,
        input  flags, done, done_rd,
        output dbg_addr,
        input  dbg_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Operand fetch / writeback stage in front of the ALU: register file, one command in flight,
// operands presented for one EXEC cycle, result and flags captured, result written back in WB.
//
// state | meaning
// IDLE  | cmd_ready high; accepted command latches operands into holding registers
// EXEC  | holding registers drive the ALU; result and flags sampled at end of cycle
// WB    | done pulse; result written to rd (discarded for r0)
module alu_sequencer #(
    parameter int BUS_SIZE  = 32,
    parameter int OP_W      = 8,
    parameter int FLAG_W    = 4,
    parameter int CARRY_BIT = 0,
    parameter int REG_COUNT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);
    localparam int RA_W = $clog2(REG_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [BUS_SIZE-1:0] a_q, a_d;
    logic [BUS_SIZE-1:0] b_q, b_d;
    logic                cin_q, cin_d;
    logic [RA_W-1:0]     rd_q, rd_d;
    logic [BUS_SIZE-1:0] res_q, res_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [BUS_SIZE-1:0] rf_q [REG_COUNT];
    logic [BUS_SIZE-1:0] rf_d [REG_COUNT];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        rd_d    = rd_q;
        res_d   = res_q;
        flags_d = flags_q;
        rf_d    = rf_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    a_d     = rf_q[bus.cmd_rs1];
                    b_d     = bus.cmd_imm_en ? bus.cmd_imm : rf_q[bus.cmd_rs2];
                    cin_d   = bus.cmd_use_carry & flags_q[CARRY_BIT];
                    rd_d    = bus.cmd_rd;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = bus.alu_result;
                flags_d = bus.alu_flags;
                state_d = WB;
            end
            WB: begin
                // r0 is hardwired to zero, so its write is simply dropped
                if (rd_q != '0) begin
                    rf_d[rd_q] = res_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            rf_q    <= rf_d;
        end
    end

    // Holding registers only change on accept, so they also hold the ALU inputs steady outside EXEC.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_cin   = cin_q;
    assign bus.flags     = flags_q;
    assign bus.done      = (state_q == WB);
    assign bus.done_rd   = rd_q;
    assign bus.dbg_data  = (bus.dbg_addr == '0) ? '0 : rf_q[bus.dbg_addr];
endmodule
